// File: rtl/pulse_gen_pkg.sv
// Shared types and default widths for the pulse train generator.
// Optional edge flags (rise/fall) are enabled with PULSE_TRAIN_GEN_EDGE_FLAGS_EN.
package pulse_gen_pkg;

    localparam int LEN_W_DEF = 8;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } pulse_gen_state_t;

endpackage

// File: rtl/pulse_gen_down_counter.sv
// Loadable down-counter that stops at zero.
// It is used for both the phase length and the remaining-pulse count.
module pulse_gen_down_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// Generates COUNT pulses of HIGH_LEN cycles separated by LOW_LEN-cycle gaps.
// Defining PULSE_TRAIN_GEN_EDGE_FLAGS_EN adds the registered rise/fall outputs.
module pulse_train_gen
    import pulse_gen_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [LEN_W-1:0] req_high_len,
    input  logic [LEN_W-1:0] req_low_len,
    input  logic [CNT_W-1:0] req_count,
    input  logic             abort,
    output logic             pulse_out,
    output logic             busy,
    output logic             done
`ifdef PULSE_TRAIN_GEN_EDGE_FLAGS_EN
    ,
    output logic             rise,
    output logic             fall
`endif
);

    pulse_gen_state_t r_state, w_state_nxt;

    logic [LEN_W-1:0] r_high_len, r_low_len;
    logic [LEN_W-1:0] w_req_h, w_req_l;
    logic             w_accept;
    logic             w_done_nxt;

    logic             w_ph_load, w_ph_dec, w_ph_zero;
    logic [LEN_W-1:0] w_ph_val;
    logic             w_pc_load, w_pc_dec, w_pc_zero;
    logic [CNT_W-1:0] w_pc_val;

    logic r_pulse, r_busy, r_done;

    assign req_ready = (r_state == IDLE) && !abort;
    assign w_accept  = req_valid && req_ready;

    // A zero length is stretched to one cycle so adjacent pulses never merge.
    assign w_req_h = (req_high_len == '0) ? LEN_W'(1) : req_high_len;
    assign w_req_l = (req_low_len  == '0) ? LEN_W'(1) : req_low_len;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_high_len <= LEN_W'(1);
            r_low_len  <= LEN_W'(1);
        end else if (w_accept) begin
            r_high_len <= w_req_h;
            r_low_len  <= w_req_l;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Counters hold (remaining - 1); zero on the phase counter ends the phase.
    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        w_ph_load   = 1'b0;
        w_ph_val    = '0;
        w_ph_dec    = 1'b0;
        w_pc_load   = 1'b0;
        w_pc_val    = '0;
        w_pc_dec    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (req_count == '0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = HIGH;
                        w_ph_load   = 1'b1;
                        w_ph_val    = w_req_h - LEN_W'(1);
                        w_pc_load   = 1'b1;
                        w_pc_val    = req_count - CNT_W'(1);
                    end
                end
            end
            HIGH: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                end else if (w_ph_zero) begin
                    if (w_pc_zero) begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = LOW;
                        w_ph_load   = 1'b1;
                        w_ph_val    = r_low_len - LEN_W'(1);
                        w_pc_dec    = 1'b1;
                    end
                end else begin
                    w_ph_dec = 1'b1;
                end
            end
            LOW: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                end else if (w_ph_zero) begin
                    w_state_nxt = HIGH;
                    w_ph_load   = 1'b1;
                    w_ph_val    = r_high_len - LEN_W'(1);
                end else begin
                    w_ph_dec = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    pulse_gen_down_counter #(.W(LEN_W)) u_phase_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_ph_load),
        .i_load_val (w_ph_val),
        .i_dec      (w_ph_dec),
        .o_zero     (w_ph_zero)
    );

    pulse_gen_down_counter #(.W(CNT_W)) u_pulse_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_pc_load),
        .i_load_val (w_pc_val),
        .i_dec      (w_pc_dec),
        .o_zero     (w_pc_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pulse <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_pulse <= (w_state_nxt == HIGH);
            r_busy  <= (w_state_nxt != IDLE);
            r_done  <= w_done_nxt;
        end
    end

    assign pulse_out = r_pulse;
    assign busy      = r_busy;
    assign done      = r_done;

`ifdef PULSE_TRAIN_GEN_EDGE_FLAGS_EN
    logic r_rise, r_fall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= (w_state_nxt == HIGH) && (r_state != HIGH);
            r_fall <= (w_state_nxt != HIGH) && (r_state == HIGH);
        end
    end

    assign rise = r_rise;
    assign fall = r_fall;
`endif

endmodule

// File: tb/tb_pulse_train_gen.sv
// Self-checking bench for pulse_train_gen; expected waveforms come from a queue-based model.
// Edge flag checks are included when PULSE_TRAIN_GEN_EDGE_FLAGS_EN is defined.
module tb_pulse_train_gen;

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_high_len;
    logic [7:0] req_low_len;
    logic [7:0] req_count;
    logic       abort;
    logic       pulse_out;
    logic       busy;
    logic       done;
`ifdef PULSE_TRAIN_GEN_EDGE_FLAGS_EN
    logic       rise;
    logic       fall;
`endif

    pulse_train_gen #(.LEN_W(8), .CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_high_len (req_high_len),
        .req_low_len  (req_low_len),
        .req_count    (req_count),
        .abort        (abort),
        .pulse_out    (pulse_out),
        .busy         (busy),
        .done         (done)
`ifdef PULSE_TRAIN_GEN_EDGE_FLAGS_EN
        ,
        .rise         (rise),
        .fall         (fall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One entry per future cycle: pulse line, busy, done.
    typedef struct packed {
        bit p;
        bit b;
        bit d;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    bit   prev_p;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Expand a request into its full cycle-by-cycle waveform.
    task automatic build(input int h, input int l, input int c);
        int he = (h == 0) ? 1 : h;
        int le = (l == 0) ? 1 : l;
        for (int p = 0; p < c; p++) begin
            for (int k = 0; k < he; k++) q.push_back('{p: 1'b1, b: 1'b1, d: 1'b0});
            if (p < c - 1)
                for (int k = 0; k < le; k++) q.push_back('{p: 1'b0, b: 1'b1, d: 1'b0});
        end
        q.push_back('{p: 1'b0, b: 1'b0, d: 1'b1});
    endtask

    task automatic model_edge(input bit v, input int h, input int l, input int c, input bit ab);
        bit acc;
        acc    = v && !cur.b && !ab;
        prev_p = cur.p;
        if (cur.b && ab) begin
            q.delete();
            cur = '0;
        end else begin
            if (acc) build(h, l, c);
            if (q.size() > 0) cur = q.pop_front();
            else cur = '0;
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".pulse"}, 32'(pulse_out), 32'(cur.p));
        chk({tag, ".busy"},  32'(busy),      32'(cur.b));
        chk({tag, ".done"},  32'(done),      32'(cur.d));
`ifdef PULSE_TRAIN_GEN_EDGE_FLAGS_EN
        chk({tag, ".rise"},  32'(rise),      32'(!prev_p && cur.p));
        chk({tag, ".fall"},  32'(fall),      32'(prev_p && !cur.p));
`endif
    endtask

    // Apply inputs for one edge, check ready, clock, then check the registered outputs.
    task automatic cyc(input string tag, input bit v, input int h, input int l, input int c, input bit ab);
        req_valid    = v;
        req_high_len = 8'(h);
        req_low_len  = 8'(l);
        req_count    = 8'(c);
        abort        = ab;
        #1;
        chk({tag, ".ready"}, 32'(req_ready), 32'(!cur.b && !ab));
        @(posedge clk);
        #1;
        model_edge(v, h, l, c, ab);
        check_outputs(tag);
    endtask

    task automatic idle_cycles(input string tag, input int n);
        for (int i = 0; i < n; i++) cyc(tag, 1'b0, 0, 0, 0, 1'b0);
    endtask

    initial begin
        rst          = 1'b0;
        req_valid    = 1'b0;
        req_high_len = '0;
        req_low_len  = '0;
        req_count    = '0;
        abort        = 1'b0;
        cur          = '0;
        prev_p       = 1'b0;
        #23;
        check_outputs("reset");
        chk("reset.ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;

        cyc("t1", 1'b1, 1, 1, 3, 1'b0);
        idle_cycles("t1", 8);

        cyc("t2a", 1'b1, 1, 5, 1, 1'b0);
        idle_cycles("t2a", 3);
        cyc("t2b", 1'b1, 3, 5, 1, 1'b0);
        idle_cycles("t2b", 5);

        cyc("t3a", 1'b1, 0, 0, 2, 1'b0);
        idle_cycles("t3a", 5);
        cyc("t3b", 1'b1, 4, 4, 0, 1'b0);
        idle_cycles("t3b", 3);

        cyc("t4", 1'b1, 4, 2, 5, 1'b0);
        idle_cycles("t4", 13);
        cyc("t4.abort", 1'b0, 0, 0, 0, 1'b1);
        idle_cycles("t4.after", 6);

        cyc("t4i", 1'b1, 2, 2, 2, 1'b1);
        idle_cycles("t4i", 3);

        for (int i = 0; i < 12; i++) cyc("t5", 1'b1, 2, 3, 2, 1'b0);
        idle_cycles("t5", 6);

        cyc("t5r", 1'b1, 3, 2, 4, 1'b0);
        idle_cycles("t5r", 4);
        #2;
        rst = 1'b0;
        #1;
        q.delete();
        cur    = '0;
        prev_p = 1'b0;
        check_outputs("t5r.async");
        chk("t5r.async.ready", 32'(req_ready), 32'd1);
        #3;
        rst = 1'b1;
        idle_cycles("t5r.post", 2);

        cyc("max_h", 1'b1, 255, 0, 2, 1'b0);
        idle_cycles("max_h", 515);
        cyc("max_c", 1'b1, 1, 1, 255, 1'b0);
        idle_cycles("max_c", 512);

        for (int i = 0; i < 600; i++) begin
            bit v  = ($urandom_range(2) == 0);
            bit ab = ($urandom_range(24) == 0);
            cyc("rand", v, int'($urandom_range(5)), int'($urandom_range(4)),
                int'($urandom_range(4)), ab);
        end
        idle_cycles("drain", 40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
